// File: rtl/spi_acc_slave.sv
// spi_acc_slave
// SPI mode-0 responder that emulates the board accelerometer's command
// protocol (0x0A = register write, 0x0B = register read, bursts with
// address auto-increment and 0x3F -> 0x00 wrap). The block runs entirely
// on the system clock. SCLK, CSN and MOSI are oversampled through
// synchronizers, and edges are detected on the synchronized copies.
//
// Optional build macro: ACC_SLAVE_SOFT_RESET_EN
//   When defined, writing 0x52 to 0x1F clears 0x20-0x3F, STATUS and the
//   sample snapshot. That write is reported on reg_wr_*.
//
// Ports:
//   CLK100MHZ       system clock
//   CPU_RESETN      asynchronous active-low reset
//   ACL_SCLK        SPI clock from master (idle low)
//   ACL_CSN         SPI chip select, active low
//   ACL_MOSI        master-to-slave data
//   ACL_MISO        slave-to-master data, changes only on SCLK falls
//   sample_valid    one-cycle strobe: x/y/z/temp_data are new
//   x/y/z/temp_data 12-bit signed samples
//   reg_wr_en       one-cycle pulse per committed register write
//   reg_wr_addr     address of the committed write
//   reg_wr_data     data of the committed write
//   busy            high while synchronized CSN is low
module spi_acc_slave #(
  parameter logic [7:0] DEVID_AD    = 8'hAD,
  parameter logic [7:0] DEVID_MST   = 8'h1D,
  parameter logic [7:0] PARTID      = 8'hF2,
  parameter logic [7:0] REVID       = 8'h01,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        ACL_SCLK,
  input  logic        ACL_CSN,
  input  logic        ACL_MOSI,
  output logic        ACL_MISO,
  input  logic        sample_valid,
  input  logic [11:0] x_data,
  input  logic [11:0] y_data,
  input  logic [11:0] z_data,
  input  logic [11:0] temp_data,
  output logic        reg_wr_en,
  output logic [5:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic        busy
);

  localparam logic [7:0] CMD_WRITE  = 8'h0A;
  localparam logic [7:0] CMD_READ   = 8'h0B;
  localparam logic [5:0] REG_STATUS = 6'h0B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, csn_prev_q;
  logic                   sclk_s, csn_s, mosi_s;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values from before the edge and ordering cannot race.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '1;   // bus idles deselected
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ACL_SCLK};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], ACL_CSN};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], ACL_MOSI};
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s  = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // SCLK activity only counts while the device is selected.
  logic sclk_rise, sclk_fall, csn_fall, csn_rise;
  assign sclk_rise = ~csn_s &  sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~csn_s & ~sclk_s &  sclk_prev_q;
  assign csn_fall  = ~csn_s &  csn_prev_q;
  assign csn_rise  =  csn_s & ~csn_prev_q;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t      state_q;
  logic [3:0]  bit_cnt_q;
  logic [6:0]  shift_q;
  logic        is_write_q;
  logic [5:0]  addr_q;
  logic [7:0]  tx_q;
  logic        miso_q;
  logic        wr_en_q;
  logic [5:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic        busy_q;
  logic        status_q;
  logic [11:0] shadow_q [4];   // 0:x 1:y 2:z 3:temp, latest sample
  logic [11:0] snap_q   [4];   // frozen at CSN fall for coherent bursts
  logic [7:0]  rw_q     [32];  // registers 0x20-0x3F

  logic [7:0]  rx_byte;
  logic        byte_done;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_byte;
  logic        soft_hit;

  assign rx_byte   = {shift_q, mosi_s};
  assign byte_done = (bit_cnt_q == 4'd7);
  // bit_cnt_q == 8 in RDATA means the current byte has fully gone out and
  // the next one loads from the following address on this same fall.
  assign rd_addr   = (bit_cnt_q == 4'd8) ? addr_q + 6'd1 : addr_q;

`ifdef ACC_SLAVE_SOFT_RESET_EN
  assign soft_hit = (addr_q == 6'h1F) && (rx_byte == 8'h52);
`else
  assign soft_hit = 1'b0;
`endif

  function automatic logic [7:0] hi_byte(input logic [11:0] s);
    return {{4{s[11]}}, s[11:8]};
  endfunction

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_byte = 8'h00;
    if (rd_addr[5]) begin
      rd_byte = rw_q[rd_addr[4:0]];
    end else begin
      case (rd_addr[4:0])
        5'h00:   rd_byte = DEVID_AD;
        5'h01:   rd_byte = DEVID_MST;
        5'h02:   rd_byte = PARTID;
        5'h03:   rd_byte = REVID;
        5'h08:   rd_byte = snap_q[0][11:4];
        5'h09:   rd_byte = snap_q[1][11:4];
        5'h0A:   rd_byte = snap_q[2][11:4];
        5'h0B:   rd_byte = {7'd0, status_q};
        5'h0E:   rd_byte = snap_q[0][7:0];
        5'h0F:   rd_byte = hi_byte(snap_q[0]);
        5'h10:   rd_byte = snap_q[1][7:0];
        5'h11:   rd_byte = hi_byte(snap_q[1]);
        5'h12:   rd_byte = snap_q[2][7:0];
        5'h13:   rd_byte = hi_byte(snap_q[2]);
        5'h14:   rd_byte = snap_q[3][7:0];
        5'h15:   rd_byte = hi_byte(snap_q[3]);
        default: rd_byte = 8'h00;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Protocol FSM, register file, samples and status
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      tx_q       <= '0;
      miso_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      status_q   <= 1'b0;
      // NOTE: these arrays are architecturally visible after reset, so they
      // are reset explicitly; that keeps them in flops rather than RAM.
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= '0;
        snap_q[i]   <= '0;
      end
      for (int i = 0; i < 32; i++) rw_q[i] <= '0;
    end else begin
      wr_en_q <= 1'b0;
      busy_q  <= ~csn_s;

      if (sample_valid) begin
        shadow_q[0] <= x_data;
        shadow_q[1] <= y_data;
        shadow_q[2] <= z_data;
        shadow_q[3] <= temp_data;
      end

      if (csn_rise) begin
        // Deselect aborts anything in flight, including a partial byte.
        state_q <= ST_IDLE;
        miso_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (csn_fall) begin
              state_q   <= ST_CMD;
              bit_cnt_q <= '0;
              snap_q    <= shadow_q;
            end
          end

          ST_CMD: begin
            if (sclk_rise) begin
              shift_q <= rx_byte[6:0];
              if (byte_done) begin
                bit_cnt_q <= '0;
                if (rx_byte == CMD_WRITE) begin
                  is_write_q <= 1'b1;
                  state_q    <= ST_ADDR;
                end else if (rx_byte == CMD_READ) begin
                  is_write_q <= 1'b0;
                  state_q    <= ST_ADDR;
                end else begin
                  state_q <= ST_IGNORE;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          ST_ADDR: begin
            if (sclk_rise) begin
              shift_q <= rx_byte[6:0];
              if (byte_done) begin
                bit_cnt_q <= '0;
                addr_q    <= rx_byte[5:0];
                state_q   <= is_write_q ? ST_WDATA : ST_RDATA;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          ST_WDATA: begin
            if (sclk_rise) begin
              shift_q <= rx_byte[6:0];
              if (byte_done) begin
                bit_cnt_q <= '0;
                addr_q    <= addr_q + 6'd1;
                if (addr_q[5]) rw_q[addr_q[4:0]] <= rx_byte;
                if (addr_q[5] || soft_hit) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= addr_q;
                  wr_data_q <= rx_byte;
                end
`ifdef ACC_SLAVE_SOFT_RESET_EN
                if (soft_hit) begin
                  status_q <= 1'b0;
                  for (int i = 0; i < 4; i++) snap_q[i] <= '0;
                  for (int i = 0; i < 32; i++) rw_q[i] <= '0;
                end
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          ST_RDATA: begin
            if (sclk_fall) begin
              if (bit_cnt_q == 4'd0 || bit_cnt_q == 4'd8) begin
                miso_q    <= rd_byte[7];
                tx_q      <= {rd_byte[6:0], 1'b0};
                addr_q    <= rd_addr;
                bit_cnt_q <= 4'd1;
                if (rd_addr == REG_STATUS) status_q <= 1'b0;
              end else begin
                miso_q    <= tx_q[7];
                tx_q      <= {tx_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          ST_IGNORE: miso_q <= 1'b0;

          default: state_q <= ST_IDLE;
        endcase
      end

      // A new sample outranks a same-cycle STATUS read-clear.
      if (sample_valid) status_q <= 1'b1;
    end
  end

  assign ACL_MISO    = miso_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_acc_slave.sv
// tb_spi_acc_slave
// Self-checking bench for spi_acc_slave (default build, soft reset off).
// Drives SPI mode-0 transactions at a half-period of HALF system clocks.
// Expected read bytes and expected register-write pulses go into
// scoreboard queues when stimulus is issued. They are popped when the DUT
// returns a byte or pulses reg_wr_en.
module tb_spi_acc_slave;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        csn = 1'b1;
  logic        mosi = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] x_data = '0, y_data = '0, z_data = '0, temp_data = '0;
  logic        miso, wr_en, busy;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;

  spi_acc_slave dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rst_n),
    .ACL_SCLK    (sclk),
    .ACL_CSN     (csn),
    .ACL_MOSI    (mosi),
    .ACL_MISO    (miso),
    .sample_valid(sample_valid),
    .x_data      (x_data),
    .y_data      (y_data),
    .z_data      (z_data),
    .temp_data   (temp_data),
    .reg_wr_en   (wr_en),
    .reg_wr_addr (wr_addr),
    .reg_wr_data (wr_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    string      name;
    logic [7:0] cmd;
    logic [7:0] addr;
    int         n;
    logic [47:0] d;   // byte i at d[47-8*i -: 8]: write data or expected read
  } vec_t;

  wr_t        wr_exp [$];
  logic [7:0] rd_exp [$];
  wr_t        mon_e;
  vec_t       tbl [15];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write-pulse scoreboard: every reg_wr_en cycle must match the queue head.
  always @(negedge clk) begin
    if (rst_n && wr_en === 1'b1) begin
      if (wr_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no write",
                 wr_addr, wr_data);
      end else begin
        mon_e = wr_exp.pop_front();
        check("wr_addr", wr_addr, mon_e.addr);
        check("wr_data", wr_data, mon_e.data);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_begin();
    csn = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic spi_end();
    wait_clk(HALF);
    csn = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      wait_clk(HALF);
      sclk = 1'b1;
      rx = {rx[6:0], miso};
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic pulse_sample(input logic [11:0] x, input logic [11:0] y,
                              input logic [11:0] z, input logic [11:0] t);
    x_data = x; y_data = y; z_data = z; temp_data = t;
    sample_valid = 1'b1;
    wait_clk(1);
    sample_valid = 1'b0;
  endtask

  task automatic do_txn(input vec_t v);
    logic [7:0] rx, b, e;
    logic [5:0] a;
    bit         is_wr;
    is_wr = (v.cmd == 8'h0A);
    for (int i = 0; i < v.n; i++) begin
      b = v.d[47-8*i -: 8];
      if (is_wr) begin
        a = v.addr[5:0] + 6'(i);
        if (a >= 6'h20) wr_exp.push_back('{a, b});
      end else begin
        rd_exp.push_back(b);
      end
    end
    spi_begin();
    spi_bits(v.cmd, 8, rx);
    spi_bits(v.addr, 8, rx);
    for (int i = 0; i < v.n; i++) begin
      spi_bits(is_wr ? v.d[47-8*i -: 8] : 8'h00, 8, rx);
      if (!is_wr) begin
        e = rd_exp.pop_front();
        check($sformatf("%s[%0d]", v.name, i), rx, e);
      end
    end
    spi_end();
  endtask

  initial begin
    logic [7:0] rx, e;
    logic [47:0] burst;

    tbl[0]  = '{"id_burst",    8'h0B, 8'h00, 4, 48'hAD1DF2010000};
    tbl[1]  = '{"status_idle", 8'h0B, 8'h0B, 1, 48'h000000000000};
    tbl[2]  = '{"wr_2d",       8'h0A, 8'h2D, 1, 48'h020000000000};
    tbl[3]  = '{"rb_2d",       8'h0B, 8'h2D, 1, 48'h020000000000};
    tbl[4]  = '{"rb_2d_hibits",8'h0B, 8'hED, 1, 48'h020000000000};
    tbl[5]  = '{"wr_wrap",     8'h0A, 8'h3F, 2, 48'h112200000000};
    tbl[6]  = '{"rd_wrap",     8'h0B, 8'h3F, 2, 48'h11AD00000000};
    tbl[7]  = '{"wr_ro",       8'h0A, 8'h05, 1, 48'hAA0000000000};
    tbl[8]  = '{"rb_ro",       8'h0B, 8'h05, 1, 48'h000000000000};
    tbl[9]  = '{"wr_1f",       8'h0A, 8'h1F, 1, 48'h520000000000};
    tbl[10] = '{"rb_1f",       8'h0B, 8'h1F, 1, 48'h000000000000};
    tbl[11] = '{"rb_2d_kept",  8'h0B, 8'h2D, 1, 48'h020000000000};
    tbl[12] = '{"wr_burst20",  8'h0A, 8'h20, 3, 48'hA55AC3000000};
    tbl[13] = '{"rd_burst1e",  8'h0B, 8'h1E, 5, 48'h0000A55AC300};
    tbl[14] = '{"ignore_cmd",  8'h5A, 8'h00, 2, 48'h000000000000};

    // Reset state
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    check("rst_miso", miso, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);

    // Single read of 0x00 with busy observed inside and after the frame
    rd_exp.push_back(8'hAD);
    spi_begin();
    check("busy_low_csn", busy, 1);
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 8, rx);
    e = rd_exp.pop_front();
    check("first_read", rx, e);
    spi_end();
    check("busy_after", busy, 0);

    // Table-driven transactions
    for (int i = 0; i < 15; i++) do_txn(tbl[i]);

    // Samples, STATUS set/clear, snapshot coherence
    pulse_sample(12'hF83, 12'h123, 12'h800, 12'h7FF);
    do_txn('{"status_set",   8'h0B, 8'h0B, 1, 48'h010000000000});
    do_txn('{"status_clear", 8'h0B, 8'h0B, 1, 48'h000000000000});

    burst = 48'h83FF230100F8;
    for (int i = 0; i < 6; i++) rd_exp.push_back(burst[47-8*i -: 8]);
    spi_begin();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h0E, 8, rx);
    for (int i = 0; i < 6; i++) begin
      spi_bits(8'h00, 8, rx);
      e = rd_exp.pop_front();
      check($sformatf("snap_burst[%0d]", i), rx, e);
      if (i == 1) pulse_sample(12'h456, 12'h9AB, 12'h001, 12'hFFE);
    end
    spi_end();

    do_txn('{"new_sample_08", 8'h0B, 8'h08, 6, 48'h459A00010000});
    do_txn('{"status_reread", 8'h0B, 8'h0B, 1, 48'h000000000000});
    do_txn('{"z_t_burst",     8'h0B, 8'h12, 4, 48'h0100FEFF0000});

    // Partial write byte aborted by CSN rise, then stray SCLK while deselected
    spi_begin();
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h30, 8, rx);
    spi_bits(8'hFF, 4, rx);
    wait_clk(HALF);
    csn = 1'b1;
    wait_clk(2 * HALF);
    for (int i = 0; i < 8; i++) begin
      mosi = 1'b1;
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
      wait_clk(HALF);
    end
    do_txn('{"aborted_30", 8'h0B, 8'h30, 1, 48'h000000000000});

    // Reset in the middle of a read
    spi_begin();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h00, 8, rx);
    wait_clk(4);
    check("miso_pre_reset", miso, 1);
    rst_n = 1'b0;
    #1;
    check("miso_in_reset", miso, 0);
    check("busy_in_reset", busy, 0);
    wait_clk(2);
    csn = 1'b1;
    sclk = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    do_txn('{"post_reset_id", 8'h0B, 8'h00, 1, 48'hAD0000000000});
    do_txn('{"post_reset_2d", 8'h0B, 8'h2D, 1, 48'h000000000000});

    wait_clk(4);
    check("wr_pending", wr_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_acc_slave.md
Name: spi_acc_slave

Overview:
SPI mode-0 responder emulating the board accelerometer's command protocol: read register, write register, and multi-byte burst.
It is the far end of the SPI link driven by SPI_Master / Comunicacion_Acc, so the accelerometer flow can be closed-loop simulated and later hosted on a second board.
It holds a 64-byte register file, with sensor data fed from parallel sample inputs.
Internally it oversamples SCLK/CSN/MOSI on the system clock; it does not run on SCLK.

Parameters:
DEVID_AD, 8'hAD, value of reg 0x00
DEVID_MST, 8'h1D, value of reg 0x01
PARTID, 8'hF2, value of reg 0x02
REVID, 8'h01, value of reg 0x03
SYNC_STAGES, 2, flip-flops per input synchronizer (min 2)

Ports:
CLK100MHZ  input  1  system clock
CPU_RESETN  input  1  asynchronous active-low reset
ACL_SCLK  input  1  SPI clock from master, idle low
ACL_CSN  input  1  chip select, active low
ACL_MOSI  input  1  master-to-slave data
ACL_MISO  output  1  slave-to-master data
sample_valid  input  1  one-cycle strobe: x/y/z/temp are new
x_data, y_data, z_data, temp_data  input  12 each  signed two's-complement samples
reg_wr_en  output  1  one-cycle pulse on each committed register write
reg_wr_addr  output  6  address of committed write
reg_wr_data  output  8  data of committed write
busy  output  1  high while CSN (synchronized) low

Behaviour:
- Reset (async assert, sync release): ACL_MISO=0, reg_wr_en=0, reg_wr_addr=0, reg_wr_data=0, busy=0, FSM=IDLE. All writable regs=0x00. Shadow samples=0. STATUS=0x00.
- Inputs pass through SYNC_STAGES FFs. Edge detect happens on the synchronized values.
- Master constraint: SCLK half-period >= SYNC_STAGES+4 system clocks.
- Register map:
  - 0x00-0x03: ID parameters.
  - 0x08/0x09/0x0A: x/y/z[11:4].
  - 0x0B: STATUS, bit0 = DATA_READY.
  - 0x0E/0x0F: X_L = x[7:0], X_H = {4 sign bits, x[11:8]}. Y at 0x10/0x11, Z at 0x12/0x13, TEMP at 0x14/0x15, same layout.
  - 0x20-0x3F: read/write.
  - All others read 0x00. Writes outside 0x20-0x3F are ignored (no reg_wr_en), except 0x1F when the optional feature is enabled.
- Shadow samples: captured on sample_valid. A snapshot is copied from shadow on the CSN falling edge, and data reads use the snapshot, so a burst is coherent. DATA_READY is set on sample_valid and cleared when byte 0x0B is shifted out; if both happen in the same cycle, set wins.
- FSM states:
  - IDLE: wait for CSN fall, then go to CMD with bit counter 0.
  - CMD: shift 8 bits MSB-first on SCLK rise. 0x0A = write, 0x0B = read, other = IGNORE. Then go to ADDR.
  - ADDR: shift 8 bits; address = bits[5:0], bits[7:6] ignored. Then go to WDATA or RDATA.
  - WDATA: each 8th SCLK rise commits the byte to addr, pulses reg_wr_en one cycle later, then increments addr.
  - RDATA: on the SCLK fall after the last ADDR bit, load the byte at addr into the TX shifter and drive its MSB. Each later SCLK fall drives the next bit. After 8 bits, addr increments and the next byte loads on that same fall.
  - IGNORE: MISO=0 until CSN rise.
- Address wraps 0x3F -> 0x00 during bursts.
- ACL_MISO is 0 in IDLE/CMD/ADDR/WDATA/IGNORE; it is updated only on synchronized SCLK falls.
- CSN rise in any state: return to IDLE within 1 cycle and set MISO=0. A partial write byte is discarded, and a partial command/address aborts.
- SCLK edges while CSN is high are ignored.
- CPU_RESETN asserted mid-transaction clears everything immediately.

Optional Feature:
ACC_SLAVE_SOFT_RESET_EN
- Defined: a write of 0x52 to 0x1F restores 0x20-0x3F to 0x00 and clears STATUS and the snapshot. The write still pulses reg_wr_en (addr 0x1F, data 0x52). Any other value written to 0x1F is ignored.
- Undefined: 0x1F is read-only like other addresses outside 0x20-0x3F, and writes to it are ignored with no reg_wr_en.

Test Plan:
- Read 0x0B,0x00 after reset, then 1 extra byte -> MISO returns 0xAD; busy high during CSN low, 0 afterwards.
- Burst read 0x0B,0x00, 4 bytes -> AD,1D,F2,01.
- Write 0x0A,0x2D,0x02 then read 0x0B,0x2D -> reg_wr_en pulse with addr 0x2D, data 0x02; readback 0x02.
- sample_valid with x=12'hF83, then read 0x0B,0x0B + 0x0E,0x0F burst:
  - STATUS reads 0x01.
  - Re-reading 0x0B returns 0x00.
  - X burst returns 0x83,0xFF.
  - A sample_valid mid-burst does not change bytes already snapshotted.
- Write burst 0x0A,0x3F,0x11,0x22 -> 0x3F=0x11, 0x00 unchanged (read-only, no pulse); the next burst wrap read of 0x3F,0x00 gives 11,AD.
- CSN raised after 4 bits of a write data byte, then CPU_RESETN pulsed mid-read:
  - No reg_wr_en on the aborted byte.
  - MISO=0 within 1 cycle of reset.
  - FSM is back in IDLE.
  - The next read of 0x00 still returns 0xAD.
